// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial sequencing controller.
package fact_pkg;

    localparam int unsigned DEF_CNT_W = 9;
    localparam int unsigned DEF_RES_W = 16;
    localparam int unsigned RES_ONE   = 1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StMul,
        StUpd,
        StDone
    } fact_state_e;

endpackage

// File: rtl/fact_shift_mul.sv
// Iterative shift-add multiplier: one multiplier bit of cnt per step into a wide partial product.
module fact_shift_mul
    import fact_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned RES_W = DEF_RES_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   step_i,
    input  logic [RES_W-1:0]       acc_i,
    input  logic [CNT_W-1:0]       cnt_i,
    output logic                   last_o,
    output logic [RES_W+CNT_W-1:0] partial_o
);

    localparam int unsigned PW = RES_W + CNT_W;
    localparam int unsigned IW = $clog2(CNT_W + 1);

    logic [PW-1:0] partial_q, partial_d;
    logic [IW-1:0] i_q, i_d;

    always_comb begin
        partial_d = partial_q;
        i_d       = i_q;
        if (clr_i) begin
            partial_d = '0;
            i_d       = '0;
        end else if (step_i) begin
            if (cnt_i[i_q]) begin
                partial_d = partial_q + ({{CNT_W{1'b0}}, acc_i} << i_q);
            end
            i_d = i_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            partial_q <= '0;
            i_q       <= '0;
        end else begin
            partial_q <= partial_d;
            i_q       <= i_d;
        end
    end

    assign last_o    = (i_q == IW'(CNT_W - 1));
    assign partial_o = partial_q;

endmodule

// File: rtl/fact_ctrl.sv
// Factorial controller: down-counts n to 1, multiplying each count into a running product.
module fact_ctrl
    import fact_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned RES_W = DEF_RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int unsigned PW = RES_W + CNT_W;

    fact_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic             mul_clr, mul_step, mul_last;
    logic [PW-1:0]    partial;

    fact_shift_mul #(
        .CNT_W (CNT_W),
        .RES_W (RES_W)
    ) u_mul (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (mul_clr),
        .step_i    (mul_step),
        .acc_i     (acc_q),
        .cnt_i     (cnt_q),
        .last_o    (mul_last),
        .partial_o (partial)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        mul_clr  = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d    = n;
                    acc_d    = RES_W'(RES_ONE);
                    ovf_d    = 1'b0;
                    result_d = '0;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                mul_clr = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    result_d = acc_q;
                    state_d  = StDone;
                end else begin
                    state_d = StMul;
                end
            end
            StMul: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d = StUpd;
                end
            end
            StUpd: begin
                // High bits of the wide partial flag that the product no longer fits.
                acc_d   = partial[RES_W-1:0];
                ovf_d   = ovf_q | (|partial[PW-1:RES_W]);
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = StCheck;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign result  = result_q;
    assign ovf     = ovf_q;
    assign cnt_out = cnt_q;

endmodule
